// File: rtl/car_sched_pkg.sv
// rtl/car_sched_pkg.sv - shared widths, state encodings and pixel record for car_scheduler
package car_sched_pkg;

  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int C_W      = 3;
  localparam int PLAYER_W = 4;
  localparam int PLAYER_H = 4;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_LAUNCH = 3'd1;
  localparam state_t S_RUN    = 3'd2;
  localparam state_t S_NEXT   = 3'd3;
  localparam state_t S_DONE   = 3'd4;

  typedef struct packed {
    logic           plot;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [C_W-1:0] colour;
  } pixel_t;

  function automatic int width_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/car_hit_detect.sv
// rtl/car_hit_detect.sv - sticky player-box collision flag on the registered pixel output
// Built only when CAR_SCHEDULER_HIT_DETECT_EN is defined.
module car_hit_detect
  import car_sched_pkg::*;
(
  input  logic           clk,
  input  logic           resetn,
  input  logic           clear,
  input  logic           plot,
  input  logic [X_W-1:0] x,
  input  logic [Y_W-1:0] y,
  input  logic [C_W-1:0] colour,
  input  logic [X_W-1:0] player_x,
  input  logic [Y_W-1:0] player_y,
  output logic           hit
);

  logic hit_q, hit_d;
  logic in_x, in_y;

  // One extra bit keeps player_x+3 from wrapping at the right/bottom screen edge
  always_comb begin
    in_x = ({1'b0, x} >= {1'b0, player_x}) &&
           ({1'b0, x} <= ({1'b0, player_x} + 9'(PLAYER_W - 1)));
    in_y = ({1'b0, y} >= {1'b0, player_y}) &&
           ({1'b0, y} <= ({1'b0, player_y} + 8'(PLAYER_H - 1)));
  end

  always_comb begin
    hit_d = hit_q;
    if (clear) begin
      hit_d = 1'b0;
    end else if (plot && (colour != '0) && in_x && in_y) begin
      hit_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hit_q <= 1'b0;
    end else begin
      hit_q <= hit_d;
    end
  end

  assign hit = hit_q;

endmodule

// File: rtl/car_scheduler.sv
// rtl/car_scheduler.sv - runs car sprite engines one at a time and muxes the active one onto the VGA port
// Optional player collision flag under CAR_SCHEDULER_HIT_DETECT_EN.
module car_scheduler
  import car_sched_pkg::*;
#(
  parameter int NUM_CARS = 6,
  parameter int TIMEOUT  = 100000
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    go,
  input  logic [NUM_CARS-1:0]     car_plot,
  input  logic [NUM_CARS-1:0]     car_finish,
  input  logic [X_W*NUM_CARS-1:0] car_x,
  input  logic [Y_W*NUM_CARS-1:0] car_y,
  input  logic [C_W*NUM_CARS-1:0] car_colour,
  output logic [NUM_CARS-1:0]     car_en,
  output logic                    plot,
  output logic [X_W-1:0]          x,
  output logic [Y_W-1:0]          y,
  output logic [C_W-1:0]          colour,
  output logic                    busy,
  output logic                    pass_done,
  output logic                    timeout_err
`ifdef CAR_SCHEDULER_HIT_DETECT_EN
  ,
  output logic                    hit,
  input  logic [X_W-1:0]          player_x,
  input  logic [Y_W-1:0]          player_y
`endif
);

  localparam int IDX_W = width_min1(NUM_CARS);
  localparam int WD_W  = width_min1(TIMEOUT);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CARS - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             terr_q, terr_d;
  pixel_t           pix_q, pix_d;

  logic           sel_plot, sel_finish;
  logic [X_W-1:0] sel_x;
  logic [Y_W-1:0] sel_y;
  logic [C_W-1:0] sel_c;

  // Only the indexed car is ever looked at; everything else on the side ports is ignored
  always_comb begin
    sel_plot   = 1'b0;
    sel_finish = 1'b0;
    sel_x      = '0;
    sel_y      = '0;
    sel_c      = '0;
    car_en     = '0;
    for (int i = 0; i < NUM_CARS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_plot   = car_plot[i];
        sel_finish = car_finish[i];
        sel_x      = car_x[i*X_W +: X_W];
        sel_y      = car_y[i*Y_W +: Y_W];
        sel_c      = car_colour[i*C_W +: C_W];
        car_en[i]  = (state_q == S_LAUNCH);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    wd_d       = wd_q;
    terr_d     = terr_q;
    pix_d      = pix_q;
    pix_d.plot = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (go) begin
          state_d = S_LAUNCH;
          idx_d   = '0;
          terr_d  = 1'b0;
        end
      end
      S_LAUNCH: begin
        wd_d    = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        pix_d.plot = sel_plot;
        if (sel_plot) begin
          pix_d.x      = sel_x;
          pix_d.y      = sel_y;
          pix_d.colour = sel_c;
        end
        if (wd_q != WD_LAST) begin
          wd_d = wd_q + 1'b1;
        end
        // A finish landing on the last watchdog cycle still counts as a clean finish
        if (sel_finish) begin
          state_d = S_NEXT;
        end else if (wd_q == WD_LAST) begin
          terr_d  = 1'b1;
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if (idx_q == IDX_LAST) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_LAUNCH;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      wd_q    <= '0;
      terr_q  <= 1'b0;
      pix_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wd_q    <= wd_d;
      terr_q  <= terr_d;
      pix_q   <= pix_d;
    end
  end

  assign plot        = pix_q.plot;
  assign x           = pix_q.x;
  assign y           = pix_q.y;
  assign colour      = pix_q.colour;
  assign busy        = (state_q != S_IDLE);
  assign pass_done   = (state_q == S_DONE);
  assign timeout_err = terr_q;

`ifdef CAR_SCHEDULER_HIT_DETECT_EN
  logic hit_clear;
  assign hit_clear = (state_q == S_IDLE) && go;

  car_hit_detect u_hit_detect (
    .clk      (clk),
    .resetn   (resetn),
    .clear    (hit_clear),
    .plot     (pix_q.plot),
    .x        (pix_q.x),
    .y        (pix_q.y),
    .colour   (pix_q.colour),
    .player_x (player_x),
    .player_y (player_y),
    .hit      (hit)
  );
`endif

endmodule

// File: tb/tb_car_scheduler.sv
// tb/tb_car_scheduler.sv - scoreboard bench for car_scheduler with behavioural car engines
module tb_car_scheduler;

  localparam int N  = 6;
  localparam int TO = 200;

  logic           clk = 1'b0;
  logic           resetn = 1'b0;
  logic           go = 1'b0;
  logic [N-1:0]   car_plot, car_finish;
  logic [8*N-1:0] car_x;
  logic [7*N-1:0] car_y;
  logic [3*N-1:0] car_colour;
  logic [N-1:0]   car_en;
  logic           plot, busy, pass_done, timeout_err;
  logic [7:0]     x;
  logic [6:0]     y;
  logic [2:0]     colour;
`ifdef CAR_SCHEDULER_HIT_DETECT_EN
  logic           hit;
  logic [7:0]     player_x = 8'd100;
  logic [6:0]     player_y = 7'd60;
`endif

  car_scheduler #(.NUM_CARS(N), .TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn), .go(go),
    .car_plot(car_plot), .car_finish(car_finish),
    .car_x(car_x), .car_y(car_y), .car_colour(car_colour),
    .car_en(car_en), .plot(plot), .x(x), .y(y), .colour(colour),
    .busy(busy), .pass_done(pass_done), .timeout_err(timeout_err)
`ifdef CAR_SCHEDULER_HIT_DETECT_EN
    , .hit(hit), .player_x(player_x), .player_y(player_y)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // car engine models and logs
  int          active = -1;
  int          cnt = 0;
  int          fin_delay[N];
  bit          rogue = 1'b0;
  bit          hit_mode = 1'b0;
  logic [7:0]  hit_x = 8'd103;
  logic [2:0]  hit_col = 3'd0;
  logic [17:0] exp_q[$];
  logic [17:0] obs_q[$];
  logic [N-1:0] en_val_q[$];
  int          en_cyc_q[$];
  int          fin_cyc_q[$];
  int          pd_cnt = 0;
  int          pd_cyc = -1;
  logic        terr_at_pd = 1'b0;
  int          hit_rise_cyc = -1;
  int          hit_pix_cyc = -1;
  logic        hit_prev = 1'b0;

  initial begin
    logic [7:0] px;
    logic [6:0] py;
    logic [2:0] pc;
    car_plot = '0; car_finish = '0; car_x = '0; car_y = '0; car_colour = '0;
    forever begin
      @(posedge clk); #1;
      car_plot = '0; car_finish = '0; car_x = '0; car_y = '0; car_colour = '0;
      if (!resetn) begin
        active = -1;
      end else if (car_en != '0) begin
        en_val_q.push_back(car_en);
        en_cyc_q.push_back(cyc);
        active = -1;
        for (int i = 0; i < N; i++) if (car_en[i]) active = i;
        cnt = 0;
      end else if (active >= 0) begin
        cnt++;
        if (fin_delay[active] != 0 && cnt == fin_delay[active]) begin
          car_finish[active] = 1'b1;
          fin_cyc_q.push_back(cyc);
          active = -1;
        end else if (cnt <= 4) begin
          px = 8'(10 * active + cnt + 1);
          py = 7'(3 * active + cnt);
          pc = 3'(active + cnt);
          if (hit_mode && active == 0 && cnt == 1) begin
            px = hit_x; py = 7'd62; pc = hit_col;
          end
          car_plot[active] = 1'b1;
          car_x[active*8 +: 8] = px;
          car_y[active*7 +: 7] = py;
          car_colour[active*3 +: 3] = pc;
          exp_q.push_back({px, py, pc});
        end
      end
      if (rogue && active >= 1) begin
        car_plot[0] = 1'b1;
        car_x[7:0] = 8'd105;
        car_y[6:0] = 7'd60;
        car_colour[2:0] = 3'd7;
        if (cyc % 7 == 0) car_finish[0] = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (pass_done) begin
        pd_cnt++;
        pd_cyc = cyc;
        terr_at_pd = timeout_err;
      end
      if (plot) obs_q.push_back({x, y, colour});
`ifdef CAR_SCHEDULER_HIT_DETECT_EN
      if (plot && x == 8'd103 && y == 7'd62 && hit_pix_cyc < 0) hit_pix_cyc = cyc;
      if (hit && !hit_prev) hit_rise_cyc = cyc;
      hit_prev = hit;
`endif
    end
  end

  task automatic clear_logs();
    exp_q.delete(); obs_q.delete(); en_val_q.delete(); en_cyc_q.delete(); fin_cyc_q.delete();
    pd_cnt = 0; pd_cyc = -1;
    for (int i = 0; i < N; i++) fin_delay[i] = 50;
  endtask

  task automatic pulse_go(output int gcyc);
    @(posedge clk); #1;
    go = 1'b1; gcyc = cyc;
    @(posedge clk); #1;
    go = 1'b0;
  endtask

  task automatic wait_pass(input int n, input string name);
    int k;
    k = 0;
    while (pd_cnt < n && k < 4000) begin
      @(posedge clk); k++;
    end
    checks++;
    if (pd_cnt < n) begin
      errors++;
      $display("FAIL %s_timeout: pass_done count %0d, required %0d", name, pd_cnt, n);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_walk(input int n, input string name);
    checks++;
    if (en_val_q.size() != n) begin
      errors++;
      $display("FAIL %s_en_count: got %0d enables, required %0d", name, en_val_q.size(), n);
    end
    for (int k = 0; k < n && k < en_val_q.size(); k++) begin
      logic [N-1:0] e;
      e = '0; e[k % N] = 1'b1;
      checks++;
      if (en_val_q[k] !== e) begin
        errors++;
        $display("FAIL %s_en_walk[%0d]: got %b, required %b", name, k, en_val_q[k], e);
      end
    end
  endtask

  task automatic check_pixels(input string name);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s_pix_count: got %0d pixels, required %0d", name, obs_q.size(), exp_q.size());
    end
    for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL %s_pix[%0d]: got %h, required %h", name, k, obs_q[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({car_en, plot, x, y, colour, busy, pass_done, timeout_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got en=%b plot=%b x=%0d y=%0d c=%0d busy=%b pd=%b terr=%b, required all 0",
               car_en, plot, x, y, colour, busy, pass_done, timeout_err);
    end
`ifdef CAR_SCHEDULER_HIT_DETECT_EN
    checks++;
    if (hit !== 1'b0) begin
      errors++;
      $display("FAIL reset_hit: got %b, required 0", hit);
    end
`endif
    resetn = 1'b1;
  endtask

  task automatic test_timeout();
    int g;
    clear_logs();
    fin_delay[3] = 0;
    pulse_go(g);
    wait_pass(1, "timeout");
    check_walk(N, "timeout");
    checks++;
    if (en_cyc_q.size() >= 5 && en_cyc_q[4] - en_cyc_q[3] != TO + 2) begin
      errors++;
      $display("FAIL timeout_skip_gap: got %0d cycles, required %0d", en_cyc_q[4] - en_cyc_q[3], TO + 2);
    end
    checks++;
    if (terr_at_pd !== 1'b1) begin
      errors++;
      $display("FAIL timeout_err_at_done: got %b, required 1", terr_at_pd);
    end
    checks++;
    if (timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_err_sticky: got %b, required 1", timeout_err);
    end
    check_pixels("timeout");
  endtask

  task automatic test_full_pass();
    int g;
    clear_logs();
    pulse_go(g);
    wait_pass(1, "full");
    check_walk(N, "full");
    checks++;
    if (en_cyc_q.size() > 0 && en_cyc_q[0] != g + 1) begin
      errors++;
      $display("FAIL full_first_en: got cycle %0d, required %0d", en_cyc_q[0], g + 1);
    end
    for (int i = 0; i + 1 < N && i + 1 < en_cyc_q.size() && i < fin_cyc_q.size(); i++) begin
      checks++;
      if (en_cyc_q[i+1] - fin_cyc_q[i] != 2) begin
        errors++;
        $display("FAIL full_gap[%0d]: got %0d, required 2", i, en_cyc_q[i+1] - fin_cyc_q[i]);
      end
    end
    checks++;
    if (fin_cyc_q.size() == N && pd_cyc != fin_cyc_q[N-1] + 2) begin
      errors++;
      $display("FAIL full_done_latency: got cycle %0d, required %0d", pd_cyc, fin_cyc_q[N-1] + 2);
    end
    checks++;
    if (pd_cnt != 1 || terr_at_pd !== 1'b0) begin
      errors++;
      $display("FAIL full_done: got count=%0d terr=%b, required count=1 terr=0", pd_cnt, terr_at_pd);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL full_busy_idle: got %b, required 0", busy);
    end
    check_pixels("full");
  endtask

  task automatic test_masking();
    int g, bad;
    clear_logs();
    rogue = 1'b1;
    pulse_go(g);
    wait_pass(1, "mask");
    rogue = 1'b0;
    check_walk(N, "mask");
    for (int i = 0; i + 1 < N && i + 1 < en_cyc_q.size() && i < fin_cyc_q.size(); i++) begin
      checks++;
      if (en_cyc_q[i+1] - fin_cyc_q[i] != 2) begin
        errors++;
        $display("FAIL mask_gap[%0d]: got %0d, required 2", i, en_cyc_q[i+1] - fin_cyc_q[i]);
      end
    end
    bad = 0;
    foreach (obs_q[k]) if (obs_q[k][17:10] == 8'd105) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL mask_rogue_pixels: got %0d, required 0", bad);
    end
    check_pixels("mask");
  endtask

  task automatic test_back_to_back();
    int g, pd1;
    clear_logs();
    @(posedge clk); #1;
    go = 1'b1; g = cyc;
    wait_pass(1, "b2b_first");
    pd1 = pd_cyc;
    repeat (3) @(posedge clk);
    #1 go = 1'b0;
    wait_pass(2, "b2b_second");
    repeat (100) @(posedge clk);
    #1;
    checks++;
    if (pd_cnt != 2) begin
      errors++;
      $display("FAIL b2b_pass_count: got %0d, required 2", pd_cnt);
    end
    check_walk(2 * N, "b2b");
    checks++;
    if (en_cyc_q.size() > N && (en_cyc_q[0] != g + 1 || en_cyc_q[N] != pd1 + 2)) begin
      errors++;
      $display("FAIL b2b_restart: got starts %0d,%0d, required %0d,%0d", en_cyc_q[0], en_cyc_q[N], g + 1, pd1 + 2);
    end
    check_pixels("b2b");
  endtask

  task automatic test_reset_mid();
    int g, k;
    clear_logs();
    pulse_go(g);
    k = 0;
    while (en_val_q.size() < 5 && k < 2000) begin
      @(posedge clk); k++;
    end
    checks++;
    if (en_val_q.size() < 5) begin
      errors++;
      $display("FAIL rmid_reach_car4: got %0d enables, required 5", en_val_q.size());
    end
    repeat (10) @(posedge clk);
    #1 resetn = 1'b0;
    #1;
    checks++;
    if ({car_en, plot, x, y, colour, busy, pass_done, timeout_err} !== '0) begin
      errors++;
      $display("FAIL rmid_outputs: got en=%b plot=%b x=%0d y=%0d c=%0d busy=%b, required all 0",
               car_en, plot, x, y, colour, busy);
    end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (60) @(posedge clk);
    checks++;
    if (pd_cnt != 0) begin
      errors++;
      $display("FAIL rmid_no_done: got %0d pass_done, required 0", pd_cnt);
    end
    clear_logs();
    pulse_go(g);
    wait_pass(1, "rmid_restart");
    check_walk(N, "rmid_restart");
    check_pixels("rmid_restart");
  endtask

`ifdef CAR_SCHEDULER_HIT_DETECT_EN
  task automatic test_hit();
    int g;
    hit_mode = 1'b1;
    clear_logs(); hit_x = 8'd103; hit_col = 3'd0;
    pulse_go(g); wait_pass(1, "hit_c0");
    checks++;
    if (hit !== 1'b0) begin
      errors++; $display("FAIL hit_colour0: got %b, required 0", hit);
    end
    clear_logs(); hit_x = 8'd104; hit_col = 3'b100;
    pulse_go(g); wait_pass(1, "hit_edge");
    checks++;
    if (hit !== 1'b0) begin
      errors++; $display("FAIL hit_outside_box: got %b, required 0", hit);
    end
    clear_logs(); hit_x = 8'd103; hit_col = 3'b100;
    hit_pix_cyc = -1; hit_rise_cyc = -1;
    pulse_go(g); wait_pass(1, "hit_in");
    checks++;
    if (hit !== 1'b1 || hit_rise_cyc != hit_pix_cyc + 1) begin
      errors++;
      $display("FAIL hit_inside_box: got hit=%b rise=%0d, required hit=1 rise=%0d", hit, hit_rise_cyc, hit_pix_cyc + 1);
    end
    check_pixels("hit_in");
    clear_logs(); hit_col = 3'd0;
    pulse_go(g); wait_pass(1, "hit_clear");
    checks++;
    if (hit !== 1'b0) begin
      errors++; $display("FAIL hit_cleared_by_go: got %b, required 0", hit);
    end
    hit_mode = 1'b0;
  endtask
`endif

  initial begin
    for (int i = 0; i < N; i++) fin_delay[i] = 50;
    test_reset();
    test_timeout();
    test_full_pass();
    test_masking();
    test_back_to_back();
    test_reset_mid();
`ifdef CAR_SCHEDULER_HIT_DETECT_EN
    test_hit();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
